// File: rtl/md5_pkg.sv
// Shared constants, FSM state type and block formatting for the MD5 search controller.
package md5_pkg;

    // MD5 chaining initial values
    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    // Padding word after a 4-byte message and the bit-length word (32 bits)
    localparam logic [31:0] PAD_WORD = 32'h00000080;
    localparam logic [31:0] LEN_WORD = 32'h00000020;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Single 512-bit block for a 4-byte candidate; word i sits at [511-32i -: 32]
    function automatic logic [511:0] fmt_block(input logic [31:0] cand);
        fmt_block = {cand, PAD_WORD, 384'd0, LEN_WORD, 32'd0};
    endfunction

endpackage

// File: rtl/md5_vld_track.sv
// Validity tracker: one bit per pipeline stage, so the tail bit says the
// round-pipeline output is a real candidate result in this cycle.
module md5_vld_track #(
    parameter int unsigned PIPE_LAT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_vld,
    output logic o_tail,
    output logic o_empty
);

    logic [PIPE_LAT-1:0] r_sr;

    // Shift the issue flag in every cycle; clear drops everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (i_clr) begin
            r_sr <= '0;
        end else begin
            r_sr <= (r_sr << 1) | PIPE_LAT'(i_vld);
        end
    end

    assign o_tail  = r_sr[PIPE_LAT-1];
    assign o_empty = (r_sr == '0);

endmodule

// File: rtl/md5_search_ctrl.sv
// Brute-force MD5 preimage search controller: issues one candidate per cycle
// into an external round pipeline and checks digests as they retire in order.
module md5_search_ctrl
    import md5_pkg::*;
#(
    parameter int unsigned PIPE_LAT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [31:0]  range_start,
    input  logic [31:0]  range_end,
    input  logic [127:0] target,
    output logic [31:0]  pipe_a0,
    output logic [31:0]  pipe_b0,
    output logic [31:0]  pipe_c0,
    output logic [31:0]  pipe_d0,
    output logic [511:0] pipe_m,
    output logic         pipe_vld,
    input  logic [31:0]  pipe_a,
    input  logic [31:0]  pipe_b,
    input  logic [31:0]  pipe_c,
    input  logic [31:0]  pipe_d,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [31:0]  found_cand,
    output logic [31:0]  cand_count,
    output logic [1:0]   dbg_state
);

    state_t       r_state;
    logic         r_busy;
    logic         r_done;
    logic         r_found;
    logic         r_pipe_vld;
    logic [31:0]  r_found_cand;
    logic [31:0]  r_cand_count;
    logic [31:0]  r_issue_ctr;
    logic [31:0]  r_check_ctr;
    logic [31:0]  r_range_end;
    logic [127:0] r_target;

    logic         w_tail;
    logic         w_empty;
    logic         w_active;
    logic         w_tail_vld;
    logic         w_hit;
    logic         w_start_ok;
    logic         w_clr;
    logic [127:0] w_digest;

    assign w_active   = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    assign w_tail_vld = w_tail && w_active;
    assign w_digest   = {pipe_a + IV_A, pipe_b + IV_B, pipe_c + IV_C, pipe_d + IV_D};
    assign w_hit      = w_tail_vld && (w_digest == r_target);
    assign w_start_ok = start && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    // In-flight results are thrown away on abort, on the first match and on a fresh start
    assign w_clr      = abort || w_hit || w_start_ok;

    md5_vld_track #(.PIPE_LAT(PIPE_LAT)) u_vld_track (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .i_vld   (r_pipe_vld),
        .o_tail  (w_tail),
        .o_empty (w_empty)
    );

    // Search FSM: abort beats everything, a match beats the issue->drain step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_pipe_vld   <= 1'b0;
            r_found_cand <= '0;
            r_cand_count <= '0;
            r_issue_ctr  <= '0;
            r_check_ctr  <= '0;
            r_range_end  <= '0;
            r_target     <= '0;
        end else if (abort) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_pipe_vld   <= 1'b0;
            r_found_cand <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_range_end  <= range_end;
                        r_target     <= target;
                        r_cand_count <= '0;
                        r_found      <= 1'b0;
                        r_found_cand <= '0;
                        r_issue_ctr  <= range_start;
                        r_check_ctr  <= range_start;
                        if (range_end >= range_start) begin
                            r_state    <= ST_ISSUE;
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                            r_pipe_vld <= 1'b1;
                        end else begin
                            r_state    <= ST_DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_pipe_vld <= 1'b0;
                        end
                    end
                end
                ST_ISSUE, ST_DRAIN: begin
                    if (w_tail_vld) begin
                        r_check_ctr  <= r_check_ctr + 32'd1;
                        r_cand_count <= r_cand_count + 32'd1;
                    end
                    if (w_hit) begin
                        r_found      <= 1'b1;
                        r_found_cand <= r_check_ctr;
                        r_state      <= ST_DONE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_pipe_vld   <= 1'b0;
                    end else if (r_state == ST_ISSUE) begin
                        // Stop on range_end without incrementing so the counter never wraps
                        if (r_issue_ctr == r_range_end) begin
                            r_state    <= ST_DRAIN;
                            r_pipe_vld <= 1'b0;
                        end else begin
                            r_issue_ctr <= r_issue_ctr + 32'd1;
                        end
                    end else if (w_empty) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pipe_a0    = IV_A;
    assign pipe_b0    = IV_B;
    assign pipe_c0    = IV_C;
    assign pipe_d0    = IV_D;
    assign pipe_m     = fmt_block(r_issue_ctr);
    assign pipe_vld   = r_pipe_vld;
    assign busy       = r_busy;
    assign done       = r_done;
    assign found      = r_found;
    assign found_cand = r_found_cand;
    assign cand_count = r_cand_count;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_md5_search_ctrl.sv
// Bench for md5_search_ctrl with a behavioural 64-cycle round-pipeline stub.
module tb_md5_search_ctrl;

    localparam int LAT = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [31:0]  range_start = '0;
    logic [31:0]  range_end = '0;
    logic [127:0] target = '0;
    logic [31:0]  pipe_a0, pipe_b0, pipe_c0, pipe_d0;
    logic [511:0] pipe_m;
    logic         pipe_vld;
    logic [31:0]  pipe_a, pipe_b, pipe_c, pipe_d;
    logic         busy, done, found;
    logic [31:0]  found_cand, cand_count;
    logic [1:0]   dbg_state;

    int checks = 0;
    int failures = 0;

    // model state shared between the driver and the compare process
    logic         m_active = 1'b0;
    int           m_cyc = 0;
    int           m_t_done = 0;
    int           m_n_issue = 0;
    logic         m_found = 1'b0;
    logic [31:0]  m_cand = '0;
    logic [31:0]  m_count = '0;
    logic [31:0]  exp_q[$];

    always #5 clk = ~clk;

    md5_search_ctrl #(.PIPE_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .range_start(range_start), .range_end(range_end), .target(target),
        .pipe_a0(pipe_a0), .pipe_b0(pipe_b0), .pipe_c0(pipe_c0), .pipe_d0(pipe_d0),
        .pipe_m(pipe_m), .pipe_vld(pipe_vld),
        .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c), .pipe_d(pipe_d),
        .busy(busy), .done(done), .found(found), .found_cand(found_cand),
        .cand_count(cand_count), .dbg_state(dbg_state)
    );

    // Stub digest-minus-IV as a deterministic function of word0
    function automatic logic [31:0] fa(input logic [31:0] x); return x * 32'h9E3779B9; endfunction
    function automatic logic [31:0] fb(input logic [31:0] x); return x ^ 32'hA5A5A5A5; endfunction
    function automatic logic [31:0] fc(input logic [31:0] x); return x + 32'h00001234; endfunction
    function automatic logic [31:0] fd(input logic [31:0] x); return ~x; endfunction

    function automatic logic [127:0] tgt_of(input logic [31:0] x);
        return {fa(x) + 32'h67452301, fb(x) + 32'hefcdab89, fc(x) + 32'h98badcfe, fd(x) + 32'h10325476};
    endfunction

    function automatic logic [511:0] blk(input logic [31:0] c);
        logic [511:0] b;
        b = '0;
        b[511:480] = c;
        b[479:448] = 32'h00000080;
        b[63:32]   = 32'h00000020;
        return b;
    endfunction

    // Round-pipeline stub: word0 delayed by LAT cycles
    logic [31:0] dly [LAT];
    always @(posedge clk) begin
        dly[0] <= pipe_m[511:480];
        for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end
    assign pipe_a = fa(dly[LAT-1]);
    assign pipe_b = fb(dly[LAT-1]);
    assign pipe_c = fc(dly[LAT-1]);
    assign pipe_d = fd(dly[LAT-1]);

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Search outcome from the rules: issue one per cycle from cycle 0, results retire
    // LAT cycles later in order, first match ends the search the cycle after it retires.
    task automatic model(input logic [31:0] rs, input logic [31:0] re, input logic [127:0] tgt,
                         output int t_done, output int n_issue, output logic f,
                         output logic [31:0] cand, output logic [31:0] count);
        longint n;
        int     m;
        f = 1'b0; cand = '0; m = -1;
        if (re < rs) begin
            t_done = 0; n_issue = 0; count = 0;
        end else begin
            n = longint'(re) - longint'(rs) + 1;
            for (longint i = 0; i < n && m < 0; i++)
                if (tgt_of(rs + 32'(i)) == tgt) m = int'(i);
            if (m < 0) begin
                t_done = int'(n) + LAT + 1; n_issue = int'(n); count = 32'(n);
            end else begin
                t_done = m + LAT + 1;
                n_issue = (n < longint'(m + LAT + 1)) ? int'(n) : m + LAT + 1;
                count = 32'(m + 1); f = 1'b1; cand = rs + 32'(m);
            end
        end
    endtask

    // Compare process: every cycle of an active search, 1 time unit after the edge
    always begin
        @(posedge clk);
        #1;
        if (m_active) begin
            chk1("busy", busy, logic'(m_cyc < m_t_done));
            chk1("done", done, logic'(m_cyc == m_t_done));
            chk1("pipe_vld", pipe_vld, logic'(m_cyc < m_n_issue));
            if (m_cyc < m_n_issue && exp_q.size() > 0)
                chkw("pipe_m", pipe_m, blk(exp_q.pop_front()));
            if (m_cyc == m_t_done) begin
                chk1("found", found, m_found);
                chk32("cand_count", cand_count, m_count);
                if (m_found) chk32("found_cand", found_cand, m_cand);
                chk32("issue_left", 32'(exp_q.size()), 32'd0);
                m_active = 1'b0;
            end
            m_cyc++;
        end
    end

    task automatic run_search(input logic [31:0] rs, input logic [31:0] re,
                              input logic [127:0] tgt, input logic poke);
        int t_done, n_issue, w;
        logic f;
        logic [31:0] cand, count;
        @(negedge clk);
        range_start = rs; range_end = re; target = tgt; start = 1'b1;
        model(rs, re, tgt, t_done, n_issue, f, cand, count);
        m_t_done = t_done; m_n_issue = n_issue; m_found = f; m_cand = cand; m_count = count;
        exp_q.delete();
        for (int i = 0; i < n_issue; i++) exp_q.push_back(rs + 32'(i));
        m_cyc = 0;
        m_active = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            // start with a different range while busy must be ignored
            repeat (2) @(negedge clk);
            range_start = 32'd500; range_end = 32'd600; target = tgt_of(32'd550); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        w = 0;
        while (m_active && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk1("search_timeout", m_active, 1'b0);
        m_active = 1'b0;
    endtask

    initial begin
        int t_done, n_issue;
        logic f, bad;
        logic [31:0] cand, count;

        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_found", found, 1'b0);
        chk1("rst_pipe_vld", pipe_vld, 1'b0);
        chk32("rst_found_cand", found_cand, 32'd0);
        chk32("rst_cand_count", cand_count, 32'd0);
        chk32("iv_a", pipe_a0, 32'h67452301);
        chk32("iv_b", pipe_b0, 32'hefcdab89);
        chk32("iv_c", pipe_c0, 32'h98badcfe);
        chk32("iv_d", pipe_d0, 32'h10325476);
        rst_n = 1'b1;

        // hand-computed pins on the model itself
        model(32'd0, 32'd9, tgt_of(32'd5), t_done, n_issue, f, cand, count);
        chk32("pin_match_tdone", 32'(t_done), 32'd70);
        chk32("pin_match_cand", cand, 32'd5);
        chk32("pin_match_count", count, 32'd6);
        model(32'd100, 32'd103, tgt_of(32'd5), t_done, n_issue, f, cand, count);
        chk32("pin_nomatch_tdone", 32'(t_done), 32'd69);
        chk32("pin_nomatch_issue", 32'(n_issue), 32'd4);
        chk1("pin_nomatch_found", f, 1'b0);
        model(32'd10, 32'd9, tgt_of(32'd5), t_done, n_issue, f, cand, count);
        chk32("pin_empty_tdone", 32'(t_done), 32'd0);
        model(32'hFFFFFFFE, 32'hFFFFFFFF, tgt_of(32'd0), t_done, n_issue, f, cand, count);
        chk32("pin_top_issue", 32'(n_issue), 32'd2);
        chk32("pin_top_count", count, 32'd2);

        // directed searches
        run_search(32'd0, 32'd9, tgt_of(32'd5), 1'b0);
        run_search(32'd100, 32'd103, tgt_of(32'd5), 1'b1);
        run_search(32'd10, 32'd9, tgt_of(32'd5), 1'b0);
        run_search(32'hFFFFFFFE, 32'hFFFFFFFF, tgt_of(32'd0), 1'b0);
        // match retires in the same cycle range_end is issued
        run_search(32'd0, 32'd64, tgt_of(32'd0), 1'b0);

        // abort on the third issue cycle; the matching result for candidate 1 must be ignored
        @(negedge clk);
        range_start = 32'd0; range_end = 32'd9; target = tgt_of(32'd1); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk1("abort_pre_busy", busy, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        chk1("abort_found", found, 1'b0);
        chk1("abort_pipe_vld", pipe_vld, 1'b0);
        bad = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (busy || done || found || pipe_vld) bad = 1'b1;
        end
        chk1("abort_quiet", bad, 1'b0);
        run_search(32'd20, 32'd22, tgt_of(32'd21), 1'b0);

        // reset pulse mid-drain
        @(negedge clk);
        range_start = 32'd0; range_end = 32'd3; target = tgt_of(32'd50); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (66) @(negedge clk);
        chk1("drain_busy", busy, 1'b1);
        chk1("drain_pipe_vld", pipe_vld, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_done", done, 1'b0);
        chk1("mid_rst_found", found, 1'b0);
        chk1("mid_rst_pipe_vld", pipe_vld, 1'b0);
        chk32("mid_rst_cand_count", cand_count, 32'd0);
        chk32("mid_rst_found_cand", found_cand, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (busy || done || found || pipe_vld || cand_count != 32'd0) bad = 1'b1;
        end
        chk1("post_rst_quiet", bad, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
